m_bpred: RTL and testbench
==========================

# m_bpred

Parametrised branch-prediction unit for the pipelined RV32I cores. It succeeds the single-global-bit-plus-direct-mapped-BTB scheme with four parts: a tagged BTB of configurable depth, a pattern history table (PHT) of 2-bit saturating counters, selectable bimodal or gshare indexing with a global history register (GHR), and misprediction statistics counters. Fetch uses it combinationally on the current PC. The execute stage trains it when a branch resolves.

## Interface
- BTB_ENTRIES, 32: BTB depth; power of 2, 4..1024; IW = log2(BTB_ENTRIES)
- PHT_ENTRIES, 256: PHT depth; power of 2, 4..4096; PW = log2(PHT_ENTRIES)
- GHR_BITS, 8: global history length; 1..PW
- MODE, 0: 0 = bimodal, 1 = gshare
- CNT_INIT, 2'b01: PHT counter reset value (weakly not-taken)

Ports:
- w_clk  in  1  clock, rising edge
- w_rst  in  1  reset, asynchronous, active-high
- i_pc  in  32  fetch PC for lookup
- o_hit  out  1  BTB valid and tag match for i_pc
- o_tkn  out  1  predict taken = o_hit & counter[1]
- o_tpc  out  32  predicted target; BTB data on hit, else 0
- o_idx  out  PW  PHT index used for this lookup; fetch carries it down the pipeline
- i_upd_v  in  1  a branch resolved this cycle
- i_upd_pc  in  32  PC of the resolved branch
- i_upd_idx  in  PW  o_idx captured when that branch was fetched
- i_upd_tkn  in  1  actual outcome
- i_upd_tpc  in  32  actual taken target
- i_upd_miss  in  1  pipeline flushed for this branch
- o_nbr  out  32  resolved-branch count
- o_nmiss  out  32  misprediction count

## Operation
- BTB entry format: {valid, tag[31:IW+2], target[31:0]}.
  - Index = pc[IW+1:2].
  - Tag = pc[31:IW+2].
- Lookup is purely combinational on i_pc.
  - BTB read gives o_hit and o_tpc.
  - PHT index: MODE 0 → pc[PW+1:2]; MODE 1 → pc[PW+1:2] XOR zero-extended GHR.
  - o_idx shows the index used.
- Update, on a clock edge where i_upd_v = 1:
  - PHT[i_upd_idx]: increment when taken, saturating at 3; decrement when not taken, saturating at 0.
  - BTB: written with {1, tag(i_upd_pc), i_upd_tpc} only when i_upd_tkn = 1. This overwrites any alias. Not-taken branches never allocate or invalidate an entry.
  - GHR ← {GHR[GHR_BITS-2:0], i_upd_tkn}. The GHR is non-speculative and updates in both modes; it only affects indexing in MODE 1.
  - o_nbr += 1.
  - o_nmiss += i_upd_miss.
  - Both counters wrap modulo 2^32.
- When i_upd_v = 0, no state changes. i_upd_miss is ignored when i_upd_v = 0.
- Reset, asynchronous, takes effect immediately:
  - All BTB valid bits = 0.
  - All PHT counters = CNT_INIT.
  - GHR = 0.
  - o_nbr = o_nmiss = 0.
  - Consequently o_hit = o_tkn = 0 and o_tpc = 0 for every PC.
- Reset asserted mid-update: reset wins and the update is lost.

## Timing
- Lookup latency: 0 cycles, combinational from i_pc.
- Update latency: state is written on the edge where i_upd_v = 1 and is visible to lookups in the next cycle.
- Lookup and update in the same cycle to the same BTB/PHT entry: the lookup returns pre-update contents. There is no bypass.
- In MODE 1, o_idx reflects the GHR before the same-cycle shift.
- At most one update per cycle. There is no handshake and the unit never stalls.

## Structure
- Shared package holds:
  - MODE_BIMODAL = 0, MODE_GSHARE = 1.
  - The 2-bit counter encodings SNT = 0, WNT = 1, WT = 2, ST = 3.
  - A saturating-counter next-state function.
- One sub-module, m_btb_tagged (parameter ENTRIES): asynchronous read, synchronous write, async-reset valid bits.
- PHT, GHR and the statistics counters live in m_bpred.
- Elaboration checks: power-of-2 depths and GHR_BITS ≤ PW.

## Test plan
- Reset, then look up i_pc = 0x100 → o_hit = 0, o_tkn = 0, o_tpc = 0, o_idx = 0x40; o_nbr = o_nmiss = 0.
- MODE 0: two updates for pc 0x100, tkn = 1, tpc 0x80, idx 0x40 → then lookup 0x100 gives o_hit = 1, o_tpc = 0x80, o_tkn = 1 (counter 1→2→3). Three not-taken updates → counter 0 and o_tkn = 0, while o_hit stays 1.
- BTB alias with defaults: a taken update for pc 0x100 then a taken update for pc 0x180 (same index 0) → lookup 0x100 gives o_hit = 0; lookup 0x180 gives o_hit = 1.
- MODE 1, GHR_BITS = 8: after updates with outcome pattern 1,0,1 the GHR = 0x05 → lookup 0x100 gives o_idx = 0x45. In the same cycle, a taken update makes o_idx still 0x45; the next cycle gives 0x4B.
- Same-cycle update and lookup of pc 0x200 on an empty BTB → o_hit = 0 that cycle, o_hit = 1 the next.
- o_nmiss preloaded via 2^32−1 miss updates (or forced) then one more miss update → wraps to 0. Assert w_rst between edges during an update → all outputs return to reset values immediately, with no write.

Source files
------------

// File: rtl/m_bpred_pkg.sv
// Shared definitions for the branch predictor: indexing modes, 2-bit counter
// encodings and the saturating counter update.
package m_bpred_pkg;

    localparam int MODE_BIMODAL = 0;
    localparam int MODE_GSHARE  = 1;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_t;

    function automatic logic [1:0] sat_ctr_next(input logic [1:0] ctr, input logic tkn);
        logic [1:0] nxt;
        nxt = ctr;
        if (tkn && (ctr != ST)) begin
            nxt = ctr + 2'd1;
        end else if (!tkn && (ctr != SNT)) begin
            nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/m_bpred_if.sv
// Fetch lookup and execute training bundle of the branch predictor.
interface m_bpred_if #(
    parameter int PW = 8
);
    logic [31:0]   i_pc;
    logic          o_hit;
    logic          o_tkn;
    logic [31:0]   o_tpc;
    logic [PW-1:0] o_idx;
    logic          i_upd_v;
    logic [31:0]   i_upd_pc;
    logic [PW-1:0] i_upd_idx;
    logic          i_upd_tkn;
    logic [31:0]   i_upd_tpc;
    logic          i_upd_miss;
    logic [31:0]   o_nbr;
    logic [31:0]   o_nmiss;

    modport master (
        output i_pc, i_upd_v, i_upd_pc, i_upd_idx, i_upd_tkn, i_upd_tpc, i_upd_miss,
        input  o_hit, o_tkn, o_tpc, o_idx, o_nbr, o_nmiss
    );

    modport slave (
        input  i_pc, i_upd_v, i_upd_pc, i_upd_idx, i_upd_tkn, i_upd_tpc, i_upd_miss,
        output o_hit, o_tkn, o_tpc, o_idx, o_nbr, o_nmiss
    );

endinterface

// File: rtl/m_btb_tagged.sv
// Direct-mapped tagged BTB: combinational read, clocked write, only the valid
// bits are reset.
module m_btb_tagged #(
    parameter int ENTRIES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rd_pc,
    output logic        rd_hit,
    output logic [31:0] rd_tgt,
    input  logic        wr_en,
    input  logic [31:0] wr_pc,
    input  logic [31:0] wr_tgt
);
    localparam int IW = $clog2(ENTRIES);
    localparam int TW = 30 - IW;

    logic [ENTRIES-1:0] valid;
    logic [TW-1:0]      tag_mem [ENTRIES];
    logic [31:0]        tgt_mem [ENTRIES];
    logic [IW-1:0]      rd_idx;
    logic [IW-1:0]      wr_idx;
    logic               unused_bits;

    assign rd_idx      = rd_pc[IW+1:2];
    assign wr_idx      = wr_pc[IW+1:2];
    assign unused_bits = ^{rd_pc[1:0], wr_pc[1:0]};

    assign rd_hit = valid[rd_idx] && (tag_mem[rd_idx] == rd_pc[31:IW+2]);
    assign rd_tgt = rd_hit ? tgt_mem[rd_idx] : 32'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Payload is not reset, but a write colliding with reset must not land.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            tag_mem[wr_idx] <= wr_pc[31:IW+2];
            tgt_mem[wr_idx] <= wr_tgt;
        end
    end

endmodule

// File: rtl/m_bpred.sv
// Branch predictor: tagged BTB plus 2-bit PHT with bimodal or gshare indexing,
// non-speculative global history and resolved-branch statistics.
module m_bpred
    import m_bpred_pkg::*;
#(
    parameter int         BTB_ENTRIES = 32,
    parameter int         PHT_ENTRIES = 256,
    parameter int         GHR_BITS    = 8,
    parameter int         MODE        = MODE_BIMODAL,
    parameter logic [1:0] CNT_INIT    = 2'b01
) (
    input logic      w_clk,
    input logic      w_rst,
    m_bpred_if.slave bp
);
    localparam int PW = $clog2(PHT_ENTRIES);

    if ((BTB_ENTRIES < 4) || (BTB_ENTRIES > 1024) ||
        ((BTB_ENTRIES & (BTB_ENTRIES - 1)) != 0)) begin : g_bad_btb
        $error("m_bpred: BTB_ENTRIES must be a power of 2 in 4..1024");
    end
    if ((PHT_ENTRIES < 4) || (PHT_ENTRIES > 4096) ||
        ((PHT_ENTRIES & (PHT_ENTRIES - 1)) != 0)) begin : g_bad_pht
        $error("m_bpred: PHT_ENTRIES must be a power of 2 in 4..4096");
    end
    if ((GHR_BITS < 1) || (GHR_BITS > PW)) begin : g_bad_ghr
        $error("m_bpred: GHR_BITS must be in 1..log2(PHT_ENTRIES)");
    end
    if ((MODE != MODE_BIMODAL) && (MODE != MODE_GSHARE)) begin : g_bad_mode
        $error("m_bpred: MODE must be 0 (bimodal) or 1 (gshare)");
    end

    logic [1:0]          pht [PHT_ENTRIES];
    logic [GHR_BITS-1:0] ghr;
    logic [31:0]         nbr;
    logic [31:0]         nmiss;
    logic [PW-1:0]       lkp_idx;
    logic                btb_hit;
    logic [31:0]         btb_tgt;

    m_btb_tagged #(
        .ENTRIES(BTB_ENTRIES)
    ) u_btb (
        .clk    (w_clk),
        .rst    (w_rst),
        .rd_pc  (bp.i_pc),
        .rd_hit (btb_hit),
        .rd_tgt (btb_tgt),
        .wr_en  (bp.i_upd_v & bp.i_upd_tkn),
        .wr_pc  (bp.i_upd_pc),
        .wr_tgt (bp.i_upd_tpc)
    );

    // The index uses the committed GHR, i.e. the value before any same-cycle shift.
    always_comb begin
        lkp_idx = bp.i_pc[PW+1:2];
        if (MODE == MODE_GSHARE) begin
            lkp_idx = lkp_idx ^ PW'(ghr);
        end
    end

    assign bp.o_hit   = btb_hit;
    assign bp.o_tpc   = btb_tgt;
    assign bp.o_idx   = lkp_idx;
    assign bp.o_tkn   = btb_hit & pht[lkp_idx][1];
    assign bp.o_nbr   = nbr;
    assign bp.o_nmiss = nmiss;

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht[i] <= CNT_INIT;
            end
            ghr   <= '0;
            nbr   <= '0;
            nmiss <= '0;
        end else if (bp.i_upd_v) begin
            pht[bp.i_upd_idx] <= sat_ctr_next(pht[bp.i_upd_idx], bp.i_upd_tkn);
            ghr               <= GHR_BITS'({ghr, bp.i_upd_tkn});
            nbr               <= nbr + 32'd1;
            nmiss             <= nmiss + 32'(bp.i_upd_miss);
        end
    end

endmodule

// File: tb/tb_m_bpred.sv
// Scoreboard bench for m_bpred: a bimodal and a gshare instance share clock,
// reset and the update stream; lookups are compared against queued expectations.
module tb_m_bpred;

    typedef struct {
        string       tag;
        int          sel;
        logic        hit;
        logic        tkn;
        logic [31:0] tpc;
        logic [7:0]  idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;
    logic [31:0] exp_nbr   = 32'd0;
    logic [31:0] exp_nmiss = 32'd0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    m_bpred_if #(.PW(8)) if0 ();
    m_bpred_if #(.PW(8)) if1 ();

    m_bpred #(
        .BTB_ENTRIES(32), .PHT_ENTRIES(256), .GHR_BITS(8), .MODE(0), .CNT_INIT(2'b01)
    ) dut0 (
        .w_clk (clk),
        .w_rst (rst),
        .bp    (if0)
    );

    m_bpred #(
        .BTB_ENTRIES(32), .PHT_ENTRIES(256), .GHR_BITS(8), .MODE(1), .CNT_INIT(2'b01)
    ) dut1 (
        .w_clk (clk),
        .w_rst (rst),
        .bp    (if1)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_chk++;
        if (obs === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, req);
        end
    endtask

    task automatic drive_pc(input logic [31:0] pc);
        if0.i_pc = pc;
        if1.i_pc = pc;
    endtask

    task automatic drive_upd(input logic [31:0] pc, input logic tkn, input logic [31:0] tpc,
                             input logic [7:0] idx, input logic miss);
        if0.i_upd_v = 1'b1; if0.i_upd_pc = pc; if0.i_upd_tkn = tkn;
        if0.i_upd_tpc = tpc; if0.i_upd_idx = idx; if0.i_upd_miss = miss;
        if1.i_upd_v = 1'b1; if1.i_upd_pc = pc; if1.i_upd_tkn = tkn;
        if1.i_upd_tpc = tpc; if1.i_upd_idx = idx; if1.i_upd_miss = miss;
    endtask

    task automatic clear_upd();
        if0.i_upd_v = 1'b0; if0.i_upd_miss = 1'b0; if0.i_upd_tkn = 1'b0;
        if1.i_upd_v = 1'b0; if1.i_upd_miss = 1'b0; if1.i_upd_tkn = 1'b0;
    endtask

    task automatic note_upd(input logic miss);
        exp_nbr   = exp_nbr + 32'd1;
        exp_nmiss = exp_nmiss + 32'(miss);
    endtask

    task automatic expect_lkp(input string tag, input int sel, input logic hit, input logic tkn,
                              input logic [31:0] tpc, input logic [7:0] idx);
        exp_t e;
        e.tag = tag; e.sel = sel; e.hit = hit; e.tkn = tkn; e.tpc = tpc; e.idx = idx;
        sbq.push_back(e);
    endtask

    task automatic sample_lkp();
        exp_t e;
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.sel == 0) begin
                check_val({e.tag, "_hit"}, 32'(if0.o_hit), 32'(e.hit));
                check_val({e.tag, "_tkn"}, 32'(if0.o_tkn), 32'(e.tkn));
                check_val({e.tag, "_tpc"}, if0.o_tpc, e.tpc);
                check_val({e.tag, "_idx"}, 32'(if0.o_idx), 32'(e.idx));
            end else begin
                check_val({e.tag, "_hit"}, 32'(if1.o_hit), 32'(e.hit));
                check_val({e.tag, "_tkn"}, 32'(if1.o_tkn), 32'(e.tkn));
                check_val({e.tag, "_tpc"}, if1.o_tpc, e.tpc);
                check_val({e.tag, "_idx"}, 32'(if1.o_idx), 32'(e.idx));
            end
        end
    endtask

    task automatic look(input string tag, input int sel, input logic [31:0] pc, input logic hit,
                        input logic tkn, input logic [31:0] tpc, input logic [7:0] idx);
        @(negedge clk);
        drive_pc(pc);
        expect_lkp(tag, sel, hit, tkn, tpc, idx);
        sample_lkp();
    endtask

    task automatic upd(input logic [31:0] pc, input logic tkn, input logic [31:0] tpc,
                       input logic [7:0] idx, input logic miss);
        @(negedge clk);
        drive_upd(pc, tkn, tpc, idx, miss);
        note_upd(miss);
        @(posedge clk);
        #1;
        clear_upd();
    endtask

    task automatic chk_cnt(input string tag);
        check_val({tag, "_nbr"}, if0.o_nbr, exp_nbr);
        check_val({tag, "_nmiss"}, if0.o_nmiss, exp_nmiss);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_upd();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_nbr   = 32'd0;
        exp_nmiss = 32'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        drive_pc(32'h0);
        if0.i_upd_pc = '0; if0.i_upd_tpc = '0; if0.i_upd_idx = '0;
        if1.i_upd_pc = '0; if1.i_upd_tpc = '0; if1.i_upd_idx = '0;
        clear_upd();
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive_pc(32'h100);
        expect_lkp("rst0", 0, 1'b0, 1'b0, 32'h0, 8'h40);
        expect_lkp("rst1", 1, 1'b0, 1'b0, 32'h0, 8'h40);
        sample_lkp();
        chk_cnt("rst");
        rst = 1'b0;

        // bimodal training and saturation on one branch
        upd(32'h100, 1'b1, 32'h80, 8'h40, 1'b1);
        look("tk1", 0, 32'h100, 1'b1, 1'b1, 32'h80, 8'h40);
        upd(32'h100, 1'b1, 32'h80, 8'h40, 1'b0);
        look("tk2", 0, 32'h100, 1'b1, 1'b1, 32'h80, 8'h40);
        upd(32'h100, 1'b0, 32'h0, 8'h40, 1'b1);
        look("nt1", 0, 32'h100, 1'b1, 1'b1, 32'h80, 8'h40);
        upd(32'h100, 1'b0, 32'h0, 8'h40, 1'b0);
        look("nt2", 0, 32'h100, 1'b1, 1'b0, 32'h80, 8'h40);
        upd(32'h100, 1'b0, 32'h0, 8'h40, 1'b0);
        look("nt3", 0, 32'h100, 1'b1, 1'b0, 32'h80, 8'h40);
        chk_cnt("cnt0");

        // miss flag without a valid update changes nothing
        @(negedge clk);
        if0.i_upd_miss = 1'b1; if0.i_upd_tkn = 1'b1; if0.i_upd_idx = 8'h40;
        if1.i_upd_miss = 1'b1; if1.i_upd_tkn = 1'b1; if1.i_upd_idx = 8'h40;
        @(posedge clk);
        #1;
        clear_upd();
        chk_cnt("idle");
        look("idle", 0, 32'h100, 1'b1, 1'b0, 32'h80, 8'h40);

        // BTB alias at index 0
        upd(32'h100, 1'b1, 32'h80, 8'h40, 1'b0);
        upd(32'h180, 1'b1, 32'h300, 8'h60, 1'b0);
        look("alias_old", 0, 32'h100, 1'b0, 1'b0, 32'h0, 8'h40);
        look("alias_new", 0, 32'h180, 1'b1, 1'b1, 32'h300, 8'h60);
        chk_cnt("alias");

        // same-cycle lookup and update: no bypass
        do_reset();
        @(negedge clk);
        drive_pc(32'h200);
        drive_upd(32'h200, 1'b1, 32'h400, 8'h80, 1'b0);
        note_upd(1'b0);
        expect_lkp("same_cyc", 0, 1'b0, 1'b0, 32'h0, 8'h80);
        sample_lkp();
        @(posedge clk);
        #1;
        clear_upd();
        look("next_cyc", 0, 32'h200, 1'b1, 1'b1, 32'h400, 8'h80);

        // gshare indexing with history 1,0,1
        do_reset();
        upd(32'h10, 1'b1, 32'h1000, 8'h04, 1'b0);
        upd(32'h14, 1'b0, 32'h0, 8'h05, 1'b0);
        upd(32'h18, 1'b1, 32'h2000, 8'h06, 1'b0);
        look("gsh_idx", 1, 32'h100, 1'b0, 1'b0, 32'h0, 8'h45);
        look("bim_idx", 0, 32'h100, 1'b0, 1'b0, 32'h0, 8'h40);
        @(negedge clk);
        drive_pc(32'h100);
        drive_upd(32'h20, 1'b1, 32'h3000, 8'h08, 1'b0);
        note_upd(1'b0);
        expect_lkp("gsh_same", 1, 1'b0, 1'b0, 32'h0, 8'h45);
        sample_lkp();
        @(posedge clk);
        #1;
        clear_upd();
        look("gsh_next", 1, 32'h100, 1'b0, 1'b0, 32'h0, 8'h4B);

        // miss counter wrap from a preloaded value
        @(negedge clk);
        force dut0.nmiss = 32'hFFFF_FFFF;
        #1;
        release dut0.nmiss;
        exp_nmiss = 32'hFFFF_FFFF;
        chk_cnt("preload");
        upd(32'h24, 1'b0, 32'h0, 8'h09, 1'b1);
        chk_cnt("wrap");

        // reset between edges during an update
        look("pre_rst", 0, 32'h10, 1'b1, 1'b1, 32'h1000, 8'h04);
        @(negedge clk);
        drive_pc(32'h10);
        drive_upd(32'h300, 1'b1, 32'h500, 8'hC0, 1'b1);
        #2;
        rst = 1'b1;
        exp_nbr   = 32'd0;
        exp_nmiss = 32'd0;
        expect_lkp("rst_mid", 0, 1'b0, 1'b0, 32'h0, 8'h04);
        sample_lkp();
        chk_cnt("rst_mid");
        @(posedge clk);
        #1;
        clear_upd();
        @(negedge clk);
        rst = 1'b0;
        look("rst_lost", 0, 32'h300, 1'b0, 1'b0, 32'h0, 8'hC0);
        chk_cnt("rst_lost");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
